// File: rtl/seq_parser_multi_if.sv
// -----------------------------------------------------------------------------
// seq_parser_multi_if
// Purpose : bundles the word-input stream, the wide record output and the
//           error/status signals of seq_parser_multi into one interface.
// Modports:
//   master - traffic source / record consumer (drives dataIn*, dataOut_ready)
//   slave  - the parser (drives dataIn_ready, dataOut*, packetLost,
//            lostCount, formatErr, errCount)
// Signals :
//   dataIn[31:0], dataIn_val, dataIn_last, dataIn_ready   input word stream
//   dataOut[MAX_WORDS*32-1:0], dataOut_bytes[15:0],
//   dataOut_stream[STREAM_W-1:0], dataOut_seq[SEQ_W-1:0],
//   dataOut_val, dataOut_ready                            record output
//   packetLost, lostCount[SEQ_W-1:0]                      continuity status
//   formatErr, errCount[15:0]                             format errors
// -----------------------------------------------------------------------------
interface seq_parser_multi_if #(
   parameter int MAX_BYTES   = 37,
   parameter int NUM_STREAMS = 32,
   parameter int SEQ_W       = 32
);
   localparam int MAX_WORDS = (MAX_BYTES + 3) / 4;
   localparam int STREAM_W  = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

   logic [31:0]             dataIn;
   logic                    dataIn_val;
   logic                    dataIn_ready;
   logic                    dataIn_last;
   logic [MAX_WORDS*32-1:0] dataOut;
   logic [15:0]             dataOut_bytes;
   logic [STREAM_W-1:0]     dataOut_stream;
   logic [SEQ_W-1:0]        dataOut_seq;
   logic                    dataOut_val;
   logic                    dataOut_ready;
   logic                    packetLost;
   logic [SEQ_W-1:0]        lostCount;
   logic                    formatErr;
   logic [15:0]             errCount;

   modport master (
      output dataIn, dataIn_val, dataIn_last, dataOut_ready,
      input  dataIn_ready, dataOut, dataOut_bytes, dataOut_stream, dataOut_seq,
             dataOut_val, packetLost, lostCount, formatErr, errCount
   );

   modport slave (
      input  dataIn, dataIn_val, dataIn_last, dataOut_ready,
      output dataIn_ready, dataOut, dataOut_bytes, dataOut_stream, dataOut_seq,
             dataOut_val, packetLost, lostCount, formatErr, errCount
   );
endinterface

// File: rtl/seq_parser_multi.sv
// -----------------------------------------------------------------------------
// seq_parser_multi
// Purpose : receive-side packet parser. Packets are 32-bit words: a header
//           word ([31:16] total length L incl. 8 header bytes, [15:0] stream
//           id), a sequence word, then big-endian payload. The payload is
//           collected in a prepare buffer (final partial word masked) and
//           handed to an output register as one wide record. Per-stream
//           sequence continuity is tracked and gaps reported; malformed
//           packets are discarded and counted.
// Ports   :
//   clk    - clock, rising edge
//   reset  - synchronous, active-high
//   bus    - seq_parser_multi_if.slave (word input, record output, status)
// Options : define PARSER_FIRST_SEQ_SYNC_EN to give every stream a seen bit;
//           the first committed packet of an unseen stream then never
//           reports a loss and just loads the table. Without it, the first
//           packet of each stream is expected to carry seq 1.
// -----------------------------------------------------------------------------
module seq_parser_multi #(
   parameter int MAX_BYTES   = 37,
   parameter int NUM_STREAMS = 32,
   parameter int SEQ_W       = 32
) (
   input  logic               clk,
   input  logic               reset,
   seq_parser_multi_if.slave  bus
);
   localparam int MAX_WORDS = (MAX_BYTES + 3) / 4;
   localparam int STREAM_W  = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
   localparam int IDX_W     = $clog2(MAX_WORDS + 1);

   localparam logic [15:0] MAX_BYTES_L   = 16'(MAX_BYTES);
   localparam logic [16:0] NUM_STREAMS_L = 17'(NUM_STREAMS);

   typedef enum logic [2:0] {
      S_HDR,
      S_SEQ,
      S_DATA,
      S_DRAIN,
      S_COMMIT
   } state_t;

   state_t state_q, state_d;

   // packet context captured from header / sequence words
   logic [15:0]         pbytes_q, pbytes_d;
   logic [IDX_W-1:0]    nwords_q, nwords_d;
   logic [STREAM_W-1:0] sid_q, sid_d;
   logic [SEQ_W-1:0]    pseq_q, pseq_d;
   logic [IDX_W-1:0]    widx_q, widx_d;

   // prepare buffer
   logic [31:0] buf_q [MAX_WORDS];
   logic [31:0] buf_d [MAX_WORDS];
   logic [MAX_WORDS*32-1:0] buf_flat;

   // output register (the second half of the ping-pong pair)
   logic [MAX_WORDS*32-1:0] out_data_q, out_data_d;
   logic [15:0]             out_bytes_q, out_bytes_d;
   logic [STREAM_W-1:0]     out_stream_q, out_stream_d;
   logic [SEQ_W-1:0]        out_seq_q, out_seq_d;
   logic                    out_val_q, out_val_d;
   logic                    lost_q, lost_d;
   logic [SEQ_W-1:0]        lost_cnt_q, lost_cnt_d;

   logic        fmt_err_q, fmt_err_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   // per-stream last committed sequence number
   logic [SEQ_W-1:0] seq_tab_q [NUM_STREAMS];

   logic             in_ready;
   logic             in_fire;
   logic             commit_fire;
   logic             err_evt;
   logic             first_pkt;
   logic [SEQ_W-1:0] exp_seq;
   logic             seq_gap;

   logic [15:0] hdr_len;
   logic [15:0] hdr_pbytes;
   logic        hdr_bad;
   logic        last_word;
   logic [31:0] word_mask;

   // ---------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------
   // Commit may use a slot that the consumer is emptying this very cycle.
   assign commit_fire = (state_q == S_COMMIT) && (!out_val_q || bus.dataOut_ready);

   // In COMMIT the input opens exactly when the commit fires; a word accepted
   // then is the next header and is handled as if in HDR.
   assign in_ready = !reset && ((state_q != S_COMMIT) || commit_fire);
   assign in_fire  = bus.dataIn_val && in_ready;

   assign hdr_len    = bus.dataIn[31:16];
   assign hdr_pbytes = hdr_len - 16'd8;
   assign hdr_bad    = (hdr_len < 16'd8) || (hdr_pbytes > MAX_BYTES_L) ||
                       ({1'b0, bus.dataIn[15:0]} >= NUM_STREAMS_L) || bus.dataIn_last;

   assign last_word = (widx_q == (nwords_q - IDX_W'(1)));

   // Keep only the valid leading bytes of the final word.
   always_comb begin
      word_mask = 32'hFFFF_FFFF;
      case (pbytes_q[1:0])
         2'd1:    word_mask = 32'hFF00_0000;
         2'd2:    word_mask = 32'hFFFF_0000;
         2'd3:    word_mask = 32'hFFFF_FF00;
         default: word_mask = 32'hFFFF_FFFF;
      endcase
   end

   assign exp_seq = seq_tab_q[sid_q] + SEQ_W'(1);
   assign seq_gap = !first_pkt && (pseq_q != exp_seq);

   // Word k of the record sits at the top end, big-endian style.
   generate
      for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_pack
         assign buf_flat[(MAX_WORDS-gi)*32-1 -: 32] = buf_q[gi];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Next-state / datapath control
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      pbytes_d = pbytes_q;
      nwords_d = nwords_q;
      sid_d    = sid_q;
      pseq_d   = pseq_q;
      widx_d   = widx_q;
      buf_d    = buf_q;
      err_evt  = 1'b0;

      case (state_q)
         S_HDR, S_COMMIT: begin
            if (commit_fire) begin
               state_d = S_HDR;
            end
            if (in_fire) begin
               if (hdr_bad) begin
                  err_evt = 1'b1;
                  state_d = bus.dataIn_last ? S_HDR : S_DRAIN;
               end else begin
                  pbytes_d = hdr_pbytes;
                  nwords_d = IDX_W'((hdr_pbytes + 16'd3) >> 2);
                  sid_d    = bus.dataIn[STREAM_W-1:0];
                  state_d  = S_SEQ;
               end
            end
         end

         S_SEQ: begin
            if (in_fire) begin
               pseq_d = bus.dataIn[SEQ_W-1:0];
               widx_d = '0;
               if (bus.dataIn_last) begin
                  if (nwords_q == '0) begin
                     state_d = S_COMMIT;
                  end else begin
                     err_evt = 1'b1;
                     state_d = S_HDR;
                  end
               end else if (nwords_q == '0) begin
                  // empty payload must end on the sequence word
                  err_evt = 1'b1;
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (in_fire) begin
               for (int k = 0; k < MAX_WORDS; k++) begin
                  if (widx_q == IDX_W'(k)) begin
                     buf_d[k] = bus.dataIn_last ? (bus.dataIn & word_mask) : bus.dataIn;
                  end
               end
               if (bus.dataIn_last) begin
                  if (last_word) begin
                     state_d = S_COMMIT;
                  end else begin
                     err_evt = 1'b1;
                     state_d = S_HDR;
                  end
               end else if (last_word) begin
                  err_evt = 1'b1;
                  state_d = S_DRAIN;
               end else begin
                  widx_d = widx_q + IDX_W'(1);
               end
            end
         end

         S_DRAIN: begin
            if (in_fire && bus.dataIn_last) begin
               state_d = S_HDR;
            end
         end

         default: state_d = S_HDR;
      endcase

      // The buffer starts every packet empty so unused bytes read as zero.
      if (err_evt || commit_fire) begin
         for (int k = 0; k < MAX_WORDS; k++) begin
            buf_d[k] = '0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Output register and error counters
   // ---------------------------------------------------------------------
   always_comb begin
      out_data_d   = out_data_q;
      out_bytes_d  = out_bytes_q;
      out_stream_d = out_stream_q;
      out_seq_d    = out_seq_q;
      out_val_d    = out_val_q;
      lost_d       = lost_q;
      lost_cnt_d   = lost_cnt_q;
      fmt_err_d    = err_evt;
      err_cnt_d    = err_cnt_q;

      if (commit_fire) begin
         out_data_d   = buf_flat;
         out_bytes_d  = pbytes_q;
         out_stream_d = sid_q;
         out_seq_d    = pseq_q;
         out_val_d    = 1'b1;
         lost_d       = seq_gap;
         lost_cnt_d   = seq_gap ? (pseq_q - exp_seq) : '0;
      end else if (out_val_q && bus.dataOut_ready) begin
         out_val_d = 1'b0;
      end

      if (err_evt && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_HDR;
         pbytes_q     <= '0;
         nwords_q     <= '0;
         sid_q        <= '0;
         pseq_q       <= '0;
         widx_q       <= '0;
         out_data_q   <= '0;
         out_bytes_q  <= '0;
         out_stream_q <= '0;
         out_seq_q    <= '0;
         out_val_q    <= 1'b0;
         lost_q       <= 1'b0;
         lost_cnt_q   <= '0;
         fmt_err_q    <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         pbytes_q     <= pbytes_d;
         nwords_q     <= nwords_d;
         sid_q        <= sid_d;
         pseq_q       <= pseq_d;
         widx_q       <= widx_d;
         out_data_q   <= out_data_d;
         out_bytes_q  <= out_bytes_d;
         out_stream_q <= out_stream_d;
         out_seq_q    <= out_seq_d;
         out_val_q    <= out_val_d;
         lost_q       <= lost_d;
         lost_cnt_q   <= lost_cnt_d;
         fmt_err_q    <= fmt_err_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   generate
      for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_buf
         always_ff @(posedge clk) begin
            if (reset) begin
               buf_q[gi] <= '0;
            end else begin
               buf_q[gi] <= buf_d[gi];
            end
         end
      end

      // Table written with the received seq on every commit, gap or not.
      for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_tab
         always_ff @(posedge clk) begin
            if (reset) begin
               seq_tab_q[gi] <= '0;
            end else if (commit_fire && (sid_q == STREAM_W'(gi))) begin
               seq_tab_q[gi] <= pseq_q;
            end
         end
      end
   endgenerate

`ifdef PARSER_FIRST_SEQ_SYNC_EN
   logic [NUM_STREAMS-1:0] seen_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         seen_q <= '0;
      end else if (commit_fire) begin
         seen_q[sid_q] <= 1'b1;
      end
   end

   assign first_pkt = !seen_q[sid_q];
`else
   assign first_pkt = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Interface outputs
   // ---------------------------------------------------------------------
   assign bus.dataIn_ready   = in_ready;
   assign bus.dataOut        = out_data_q;
   assign bus.dataOut_bytes  = out_bytes_q;
   assign bus.dataOut_stream = out_stream_q;
   assign bus.dataOut_seq    = out_seq_q;
   assign bus.dataOut_val    = out_val_q;
   assign bus.packetLost     = lost_q;
   assign bus.lostCount      = lost_cnt_q;
   assign bus.formatErr      = fmt_err_q;
   assign bus.errCount       = err_cnt_q;

endmodule

// File: tb/tb_seq_parser_multi.sv
// -----------------------------------------------------------------------------
// tb_seq_parser_multi
// Purpose : directed self-checking bench for seq_parser_multi with the
//           default parameters (37 bytes, 32 streams, 32-bit seq).
// -----------------------------------------------------------------------------
module tb_seq_parser_multi;
   localparam int MAX_BYTES   = 37;
   localparam int NUM_STREAMS = 32;
   localparam int SEQ_W       = 32;
   localparam int REC_W       = ((MAX_BYTES + 3) / 4) * 32;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   fmt_cnt = 0;

   always #5 clk = ~clk;

   seq_parser_multi_if #(
      .MAX_BYTES(MAX_BYTES), .NUM_STREAMS(NUM_STREAMS), .SEQ_W(SEQ_W)
   ) bus ();

   seq_parser_multi #(
      .MAX_BYTES(MAX_BYTES), .NUM_STREAMS(NUM_STREAMS), .SEQ_W(SEQ_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // formatErr pulses last a whole cycle, so one negedge sample per pulse.
   always @(negedge clk) begin
      if (bus.formatErr) fmt_cnt++;
   end

   task automatic chk(input string tag, input logic [REC_W-1:0] obs, input logic [REC_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [REC_W-1:0] mk_rec(input logic [31:0] w0, input logic [31:0] w1,
                                                input logic [31:0] w2);
      return {w0, w1, w2, {(REC_W-96){1'b0}}};
   endfunction

   // Drive one word from a negedge; returns at the negedge after acceptance.
   task automatic send_word(input logic [31:0] d, input logic l);
      logic acc = 1'b0;
      bus.dataIn      = d;
      bus.dataIn_last = l;
      bus.dataIn_val  = 1'b1;
      for (int n = 0; n < 50 && !acc; n++) begin
         acc = bus.dataIn_ready;
         @(negedge clk);
      end
      bus.dataIn_val  = 1'b0;
      bus.dataIn_last = 1'b0;
      chk("word_accept", acc, 1'b1);
   endtask

   task automatic wait_rec();
      for (int n = 0; n < 20 && !bus.dataOut_val; n++) @(negedge clk);
      chk("rec_val", bus.dataOut_val, 1'b1);
   endtask

   task automatic consume();
      bus.dataOut_ready = 1'b1;
      @(negedge clk);
      bus.dataOut_ready = 1'b0;
      chk("consumed", bus.dataOut_val, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      reset             = 1'b1;
      bus.dataIn        = '0;
      bus.dataIn_val    = 1'b0;
      bus.dataIn_last   = 1'b0;
      bus.dataOut_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", bus.dataIn_ready, 1'b0);
      chk("rst_val", bus.dataOut_val, 1'b0);
      chk("rst_data", bus.dataOut, '0);
      chk("rst_bytes", bus.dataOut_bytes, 16'd0);
      chk("rst_errcnt", bus.errCount, 16'd0);
      chk("rst_lost", {bus.packetLost, bus.lostCount, bus.formatErr}, '0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_ready", bus.dataIn_ready, 1'b1);

      // Stream 3 seq 1, 5 bytes; final word masked to its first byte.
      send_word(32'h000D_0003, 1'b0);
      send_word(32'h0000_0001, 1'b0);
      send_word(32'hAABB_CCDD, 1'b0);
      send_word(32'hEE12_3456, 1'b1);
      chk("lat_early", bus.dataOut_val, 1'b0);
      @(negedge clk);
      chk("lat_val", bus.dataOut_val, 1'b1);
      chk("p1_bytes", bus.dataOut_bytes, 16'd5);
      chk("p1_stream", bus.dataOut_stream, 5'd3);
      chk("p1_seq", bus.dataOut_seq, 32'd1);
      chk("p1_lost", bus.packetLost, 1'b0);
      chk("p1_rec", bus.dataOut, mk_rec(32'hAABBCCDD, 32'hEE000000, 32'h0));
      @(negedge clk);
      chk("p1_hold_val", bus.dataOut_val, 1'b1);
      chk("p1_hold_seq", bus.dataOut_seq, 32'd1);
      $display("pkt stream 3 seq 1 bytes %0d", bus.dataOut_bytes);
      consume();

      // Stream 3 seq 4: gap of 2; 4 bytes kept whole.
      send_word(32'h000C_0003, 1'b0);
      send_word(32'h0000_0004, 1'b0);
      send_word(32'h1122_3344, 1'b1);
      wait_rec();
      chk("p2_lost", bus.packetLost, 1'b1);
      chk("p2_lostcnt", bus.lostCount, 32'd2);
      chk("p2_rec", bus.dataOut, mk_rec(32'h11223344, 32'h0, 32'h0));
      $display("pkt stream 3 seq 4 lost %0d", bus.lostCount);
      consume();

      // Stream 3 seq 5: continuous after the table took 4.
      send_word(32'h0009_0003, 1'b0);
      send_word(32'h0000_0005, 1'b0);
      send_word(32'h5566_7788, 1'b1);
      wait_rec();
      chk("p3_lost", bus.packetLost, 1'b0);
      chk("p3_lostcnt", bus.lostCount, 32'd0);
      chk("p3_rec", bus.dataOut, mk_rec(32'h55000000, 32'h0, 32'h0));
      $display("pkt stream 3 seq 5 lost %0d", bus.packetLost);
      consume();

      // Empty payload: L = 8, last on the sequence word.
      send_word(32'h0008_0007, 1'b0);
      send_word(32'h0000_0001, 1'b1);
      chk("p4_lat_early", bus.dataOut_val, 1'b0);
      @(negedge clk);
      chk("p4_val", bus.dataOut_val, 1'b1);
      chk("p4_bytes", bus.dataOut_bytes, 16'd0);
      chk("p4_stream", bus.dataOut_stream, 5'd7);
      chk("p4_rec", bus.dataOut, '0);
      chk("p4_lost", bus.packetLost, 1'b0);
      $display("pkt stream 7 empty payload");
      consume();

      // L = 7: format error, remaining word drained.
      send_word(32'h0007_0002, 1'b0);
      send_word(32'h0000_0001, 1'b1);
      @(negedge clk);
      chk("e1_pulses", fmt_cnt, 1);
      chk("e1_errcnt", bus.errCount, 16'd1);
      chk("e1_noval", bus.dataOut_val, 1'b0);
      $display("pkt L=7 discarded errCount %0d", bus.errCount);

      // Back-pressure: record A held while B (3 words) is fully received.
      send_word(32'h000C_0005, 1'b0);
      send_word(32'h0000_0001, 1'b0);
      send_word(32'h0102_0304, 1'b1);
      wait_rec();
      send_word(32'h0014_0005, 1'b0);
      send_word(32'h0000_0002, 1'b0);
      send_word(32'hA1A2_A3A4, 1'b0);
      send_word(32'hB1B2_B3B4, 1'b0);
      send_word(32'hC1C2_C3C4, 1'b1);
      chk("bp_ready0", bus.dataIn_ready, 1'b0);
      chk("bp_holdA", bus.dataOut_seq, 32'd1);
      @(negedge clk);
      chk("bp_ready0b", bus.dataIn_ready, 1'b0);
      chk("bp_holdA_rec", bus.dataOut, mk_rec(32'h01020304, 32'h0, 32'h0));
      bus.dataOut_ready = 1'b1;
      #1;
      chk("bp_ready_free", bus.dataIn_ready, 1'b1);
      @(negedge clk);
      bus.dataOut_ready = 1'b0;
      chk("bp_B_val", bus.dataOut_val, 1'b1);
      chk("bp_B_seq", bus.dataOut_seq, 32'd2);
      chk("bp_B_bytes", bus.dataOut_bytes, 16'd12);
      chk("bp_B_rec", bus.dataOut, mk_rec(32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4));
      chk("bp_B_lost", bus.packetLost, 1'b0);
      $display("pkt stream 5 seq 2 after back-pressure");
      consume();

      // Stream id 40: drained, no record, table entry 8 untouched.
      send_word(32'h0010_0028, 1'b0);
      send_word(32'h0000_0063, 1'b0);
      send_word(32'h1111_1111, 1'b0);
      send_word(32'h2222_2222, 1'b1);
      @(negedge clk);
      chk("e2_pulses", fmt_cnt, 2);
      chk("e2_errcnt", bus.errCount, 16'd2);
      chk("e2_noval", bus.dataOut_val, 1'b0);
      send_word(32'h000C_0008, 1'b0);
      send_word(32'h0000_0001, 1'b0);
      send_word(32'h3333_3333, 1'b1);
      wait_rec();
      chk("e2_tab_lost", bus.packetLost, 1'b0);
      chk("e2_tab_stream", bus.dataOut_stream, 5'd8);
      $display("pkt stream 40 discarded, stream 8 seq 1 clean");
      consume();

      // Reset mid-packet abandons it silently.
      send_word(32'h000C_0009, 1'b0);
      send_word(32'h0000_0007, 1'b0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("mr_val", bus.dataOut_val, 1'b0);
      chk("mr_errcnt", bus.errCount, 16'd0);
      @(negedge clk);
      chk("mr_pulses", fmt_cnt, 2);
      send_word(32'h000C_0009, 1'b0);
      send_word(32'h0000_0001, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b1);
      wait_rec();
      chk("mr_seq", bus.dataOut_seq, 32'd1);
      chk("mr_lost", bus.packetLost, 1'b0);
      chk("mr_rec", bus.dataOut, mk_rec(32'hDEADBEEF, 32'h0, 32'h0));
      $display("pkt stream 9 seq 1 after reset");
      consume();

      // Last on the sequence word with a non-empty payload.
      send_word(32'h000C_0001, 1'b0);
      send_word(32'h0000_0001, 1'b1);
      @(negedge clk);
      chk("e3_errcnt", bus.errCount, 16'd1);
      $display("pkt early last on seq word discarded");

      // Last on payload word 0 of a 2-word payload.
      send_word(32'h0010_0001, 1'b0);
      send_word(32'h0000_0002, 1'b0);
      send_word(32'h4444_4444, 1'b1);
      @(negedge clk);
      chk("e4_errcnt", bus.errCount, 16'd2);
      chk("e4_pulses", fmt_cnt, 4);
      chk("e4_noval", bus.dataOut_val, 1'b0);
      $display("pkt early last in payload discarded");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
